interpolation: RTL and testbench
================================

# interpolation

Integer-factor interpolator for the transmit sample path. It accepts input samples at a low rate through a valid/ready handshake and emits one output sample every clock. Each input sample produces exactly INTERP_FACTOR output samples. It raises the baseband sample rate before the pulse-shaping/DAC stage and is the counterpart of the receive-side decimator.

## Interface
- INTERP_FACTOR, 6: output samples per input sample; legal range 2..16.
- DATA_W, 16: sample width in bits, two's complement.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- en  in  1  run enable; when low, no new sample period starts.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data this cycle (combinational).
- out_data  out  DATA_W  output sample (registered).
- out_valid  out  1  out_data is valid (registered).
- out_first  out  1  out_data is phase 0 of a new input sample (registered).
- underrun  out  1  sticky flag: a sample period ended with no next sample available.
- clear_underrun  in  1  single-cycle pulse that clears underrun.

## Operation
- One-entry input buffer holds buf_data and buf_full.
  - An accept occurs on an edge where in_valid && in_ready; the edge sets buf_full.
  - in_ready = !buf_full || load, so the buffer is refilled in the same cycle it is drained.
- Phase counter: $clog2(INTERP_FACTOR) bits, runs 0..INTERP_FACTOR-1, and indexes the output currently presented.
- States:
  - IDLE: out_valid=0, out_data=0, out_first=0.
  - RUN: out_valid=1 every cycle.
- load = buf_full && en && (state==IDLE || (state==RUN && phase==INTERP_FACTOR-1)).
- On a load edge:
  - active <= buf_data, phase <= 0, state <= RUN.
  - out_data <= buf_data, out_first <= 1.
  - buf_full clears unless a new accept happens on the same edge.
- In RUN with phase < INTERP_FACTOR-1: phase increments, out_first <= 0, out_data follows the Configuration rule.
- At phase == INTERP_FACTOR-1 with no load:
  - If en is high and buf_full is 0: this is an underrun. state <= IDLE, out_valid <= 0, out_data <= 0, underrun <= 1.
  - If en is low: state <= IDLE with no underrun (graceful stop). The current sample period always completes.
- Input is accepted in both states regardless of en.
- If clear_underrun and a new underrun occur on the same edge, set wins.
- No arithmetic: samples pass through unscaled and keep full DATA_W width.
- While reset is asserted: state=IDLE, phase=0, buf_full=0, active=0, out_data=0, out_valid=0, out_first=0, underrun=0.
  - Reset mid-period aborts the period immediately and discards the buffered sample.

## Timing
- Latency from IDLE: accept at edge T, load at edge T+1, first output visible after T+1.
- Steady state: input samples are consumed at most one per INTERP_FACTOR cycles, with no bubbles in out_valid as long as each next sample is accepted by the edge where phase reaches INTERP_FACTOR-2.
- out_first is high for exactly 1 of every INTERP_FACTOR valid cycles.
- in_ready is combinational from buf_full, state, phase and en. It has no combinational path from in_valid.

## Configuration
- INTERP_ZERO_STUFF_EN defined: out_data = active at phase 0 and 0 at phases 1..INTERP_FACTOR-1. This is zero-stuffing, intended for a following pulse-shaping filter.
- Not defined: out_data = active for all INTERP_FACTOR phases (sample-and-hold).
- Handshake, phase counter, out_first and underrun behaviour are identical in both builds.

## Structure
- Package interp_pkg holds:
  - interp_state_e enum {IDLE, RUN}
  - INTERP_FACTOR_MAX = 16
  - PHASE_W = $clog2(INTERP_FACTOR_MAX)
- Sub-module interp_in_buf: the one-entry buffer. Inputs are in_data, in_valid and load; outputs are in_ready, buf_data and buf_full.
- The top level holds the FSM, phase counter, output registers and underrun flag.

## Test plan
All scenarios use INTERP_FACTOR=6 unless stated.
- Reset: drive reset=0 mid-RUN with buf_full=1 -> all outputs go to 0 immediately, buffer is empty, and in_ready=1 after release.
- Single sample, hold build: accept 16'h1234 with en=1 -> out_valid for exactly 6 cycles with out_data=16'h1234, out_first on the first cycle only, then IDLE and underrun=1.
- Continuous stream, zero-stuff build: feed 16'h0001, 16'h8000, 16'h7FFF back-to-back -> output pattern 0001,0,0,0,0,0,8000,0,0,0,0,0,7FFF,0… with no out_valid gap between periods.
- Back-pressure: hold in_valid=1 continuously -> in_ready pulses once per 6 cycles after the buffer fills, and no sample is lost or duplicated.
- en dropped mid-period at phase 2 -> the period completes through phase 5, then IDLE with underrun=0; buffered sample is kept and loaded when en returns.
- Underrun/clear race: clear_underrun pulsed on the same edge as a new underrun -> underrun=1. A later pulse on its own -> underrun=0.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared types and limits for the integer-factor interpolator.
// Optional build macro used by the top: INTERP_ZERO_STUFF_EN.
package interp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } interp_state_e;

   localparam int INTERP_FACTOR_MAX = 16;
   localparam int PHASE_W           = $clog2(INTERP_FACTOR_MAX);

endpackage

// File: rtl/interp_in_buf.sv
// One-entry input buffer for the interpolator; refills on the same edge
// it is drained so a waiting source sees in_ready during a load.
module interp_in_buf #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              load,
   output logic              in_ready,
   output logic [DATA_W-1:0] buf_data,
   output logic              buf_full
);

   logic [DATA_W-1:0] buf_data_q;
   logic              buf_full_q;
   logic              accept;

   assign in_ready = !buf_full_q || load;
   assign accept   = in_valid && in_ready;

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_data_q <= '0;
         buf_full_q <= 1'b0;
      end else begin
         if (accept) begin
            buf_data_q <= in_data;
            buf_full_q <= 1'b1;
         end else if (load) begin
            buf_full_q <= 1'b0;
         end
      end
   end

   assign buf_data = buf_data_q;
   assign buf_full = buf_full_q;

endmodule

// File: rtl/interpolation.sv
// Integer-factor interpolator: each accepted sample yields INTERP_FACTOR outputs.
// Define INTERP_ZERO_STUFF_EN for zero-stuffing; default is sample-and-hold.
module interpolation #(
   parameter int INTERP_FACTOR = 6,
   parameter int DATA_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_first,
   output logic              underrun,
   input  logic              clear_underrun
);
   import interp_pkg::*;

   localparam int              PH_W       = $clog2(INTERP_FACTOR);
   localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(INTERP_FACTOR - 1);

   interp_state_e     state_q;
   logic [PH_W-1:0]   phase_q;
   logic [DATA_W-1:0] active_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              out_first_q;
   logic              underrun_q;

   logic [DATA_W-1:0] buf_data;
   logic              buf_full;
   logic              last_phase;
   logic              load;
   logic              underrun_set;

   interp_in_buf #(
      .DATA_W (DATA_W)
   ) u_in_buf (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .load     (load),
      .in_ready (in_ready),
      .buf_data (buf_data),
      .buf_full (buf_full)
   );

   assign last_phase = (phase_q == PHASE_LAST);
   assign load = buf_full && en &&
                 ((state_q == IDLE) || ((state_q == RUN) && last_phase));
   // A period ending while enabled with nothing buffered starves the DAC path.
   assign underrun_set = (state_q == RUN) && last_phase && en && !buf_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         active_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_first_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         if (load) begin
            state_q     <= RUN;
            phase_q     <= '0;
            active_q    <= buf_data;
            out_data_q  <= buf_data;
            out_valid_q <= 1'b1;
            out_first_q <= 1'b1;
         end else if (state_q == RUN) begin
            if (!last_phase) begin
               phase_q     <= phase_q + PH_W'(1);
               out_valid_q <= 1'b1;
               out_first_q <= 1'b0;
`ifdef INTERP_ZERO_STUFF_EN
               out_data_q  <= '0;
`else
               out_data_q  <= active_q;
`endif
            end else begin
               // Period finished with no follow-on sample (underrun or en low).
               state_q     <= IDLE;
               phase_q     <= '0;
               out_valid_q <= 1'b0;
               out_first_q <= 1'b0;
               out_data_q  <= '0;
            end
         end

         if (underrun_set) begin
            underrun_q <= 1'b1;
         end else if (clear_underrun) begin
            underrun_q <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_first = out_first_q;
   assign underrun  = underrun_q;

endmodule

// File: tb/tb_interpolation.sv
// Scoreboard bench for interpolation (INTERP_FACTOR=6); honours INTERP_ZERO_STUFF_EN.
module tb_interpolation;

   localparam int F = 6;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] data;
      logic         first;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_first;
   logic         underrun;
   logic         clear_underrun = 1'b0;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   interpolation #(.INTERP_FACTOR(F), .DATA_W(W)) dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_first      (out_first),
      .underrun       (underrun),
      .clear_underrun (clear_underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs are queued when the handshake completes.
   always @(posedge clk) begin
      if (reset && in_valid && in_ready) begin
         for (int p = 0; p < F; p++) begin
            exp_t e;
`ifdef INTERP_ZERO_STUFF_EN
            e.data = (p == 0) ? in_data : '0;
`else
            e.data = in_data;
`endif
            e.first = (p == 0);
            sb.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (reset && out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_first", 32'(out_first), 32'(e.first));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [W-1:0] d);
      int n = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic count_run(output int len);
      int n = 0;
      len = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check("run_start_timeout", 32'd0, 32'd1);
      while (out_valid && len < 200) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (out_valid) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic pulse_clear();
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
   endtask

   int len;
   int ready_cyc[5];

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_first", 32'(out_first), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Single sample: exactly F valid cycles, then underrun.
      en = 1'b1;
      send(16'h1234);
      count_run(len);
      check("single_run_len", 32'(len), 32'(F));
      check("single_underrun", 32'(underrun), 32'd1);
      pulse_clear();
      check("single_cleared", 32'(underrun), 32'd0);

      // Back-to-back stream including sign and max-positive extremes.
      fork
         begin
            send(16'h0001);
            send(16'h8000);
            send(16'h7FFF);
         end
         count_run(len);
      join
      check("stream_no_gap_len", 32'(len), 32'(3 * F));
      check("stream_underrun", 32'(underrun), 32'd1);
      pulse_clear();

      // Back-pressure: in_valid held high, data advances on each accept.
      begin
         int sent = 0;
         int cyc = 0;
         in_valid = 1'b1;
         in_data  = 16'hA000;
         while (sent < 5 && cyc < 200) begin
            if (in_ready) begin
               ready_cyc[sent] = cyc;
               sent++;
               @(negedge clk);
               cyc++;
               in_data = in_data + 16'h0011;
            end else begin
               @(negedge clk);
               cyc++;
            end
         end
         in_valid = 1'b0;
         check("bp_sent", 32'(sent), 32'd5);
         check("bp_fill", 32'(ready_cyc[1] - ready_cyc[0]), 32'd1);
         for (int i = 2; i < 5; i++) check("bp_interval", 32'(ready_cyc[i] - ready_cyc[i-1]), 32'(F));
      end
      wait_idle();
      check("bp_drained", 32'(sb.size()), 32'd0);
      check("bp_underrun", 32'(underrun), 32'd1);

      // Reset mid-period with a buffered sample: everything discarded.
      send(16'h5555);
      send(16'h6666);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb.delete();
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_out_first", 32'(out_first), 32'd0);
      check("midrst_underrun", 32'(underrun), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_no_output", 32'(out_valid), 32'd0);

      // en dropped at phase 2: period completes, buffered sample kept.
      send(16'hC0DE);
      send(16'hBEEF);
      check("endrop_phase0", 32'(out_first), 32'd1);
      repeat (2) @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      check("endrop_idle", 32'(out_valid), 32'd0);
      check("endrop_no_underrun", 32'(underrun), 32'd0);
      check("endrop_buf_kept", 32'(in_ready), 32'd0);
      en = 1'b1;
      count_run(len);
      check("endrop_resume_len", 32'(len), 32'(F));
      check("endrop_drained", 32'(sb.size()), 32'd0);
      pulse_clear();

      // clear_underrun on the same edge as a new underrun: set wins.
      send(16'h0F0F);
      begin
         int n = 0;
         while (!out_first && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("race_start", 32'(out_first), 32'd1);
      end
      repeat (F - 1) @(negedge clk);
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      check("race_set_wins", 32'(underrun), 32'd1);
      check("race_idle", 32'(out_valid), 32'd0);
      pulse_clear();
      check("race_clear_alone", 32'(underrun), 32'd0);
      check("final_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
